// File: rtl/video_pkg.sv
// Shared video-path definitions: font geometry, font address width, blink states
// and the word carried down the glyph pipeline.
package video_pkg;

    localparam int FONT_H     = 16;
    localparam int GLYPH_W    = 8;
    localparam int FONT_CHARS = 128;
    localparam int FONT_AW    = $clog2(FONT_CHARS * FONT_H);
    localparam int COL_W      = $clog2(GLYPH_W);

    typedef enum logic {
        SHOW = 1'b0,
        HIDE = 1'b1
    } blink_state_t;

    typedef struct packed {
        logic             hit;
        logic [COL_W-1:0] col;
    } pipe_word_t;

    // Column inside the glyph: low bits of the offset from the first glyph edge.
    function automatic logic [COL_W-1:0] glyph_col(input logic [9:0] draw_x,
                                                   input logic [9:0] x0);
        logic [9:0] rel;
        rel = draw_x - x0;
        return rel[COL_W-1:0];
    endfunction

endpackage

// File: rtl/font_glyph_reader_if.sv
// Pixel-path bundle between the text locators, the font ROM and the colour mapper.
interface font_glyph_reader_if;
    import video_pkg::*;

    logic               pix_en;
    logic               frame_start;
    logic               blink_on;
    logic [9:0]         DrawX;
    logic               glyph_hit;
    logic [FONT_AW-1:0] addr_in;
    logic [FONT_AW-1:0] rom_addr;
    logic [7:0]         rom_data;
    logic               pixel_on;
    logic               pixel_vld;

    modport master (
        output pix_en, frame_start, blink_on, DrawX, glyph_hit, addr_in, rom_data,
        input  rom_addr, pixel_on, pixel_vld
    );

    modport slave (
        input  pix_en, frame_start, blink_on, DrawX, glyph_hit, addr_in, rom_data,
        output rom_addr, pixel_on, pixel_vld
    );

endinterface

// File: rtl/font_glyph_reader_glyph_pipe.sv
// DEPTH-stage shift register carrying {hit, col}; advances only on the pixel strobe.
module glyph_pipe
    import video_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       en,
    input  pipe_word_t din,
    output pipe_word_t dout
);

    pipe_word_t stage [DEPTH];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/font_glyph_reader.sv
// Turns locator font addresses and hit flags into a registered pixel-on for the
// colour mapper, aligning hit/column with the synchronous font ROM and blinking text.
module font_glyph_reader
    import video_pkg::*;
#(
    parameter int ROM_LAT      = 1,
    parameter int X0           = 527,
    parameter int BLINK_FRAMES = 30
) (
    input  logic Clk,
    input  logic Reset_n,
    font_glyph_reader_if.slave bus
);

    localparam int               CNT_W   = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
    localparam logic [9:0]       X0_V    = 10'(X0);
    localparam logic [COL_W-1:0] MSB_COL = COL_W'(GLYPH_W - 1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(BLINK_FRAMES - 1);

    logic [FONT_AW-1:0] rom_addr_q;
    pipe_word_t         in_word;
    pipe_word_t         pipe_out;
    logic               pixel_on_q;
    logic               pixel_vld_q;
    logic               blank;
    logic               lit;

    // The address register and in_word form one stage, so the pipe adds exactly
    // ROM_LAT more and its output meets the ROM data for the same pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            in_word    <= '0;
        end else if (bus.pix_en) begin
            rom_addr_q <= bus.addr_in;
            in_word    <= '{hit: bus.glyph_hit, col: glyph_col(bus.DrawX, X0_V)};
        end
    end

    glyph_pipe #(
        .DEPTH (ROM_LAT)
    ) u_glyph_pipe (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (bus.pix_en),
        .din     (in_word),
        .dout    (pipe_out)
    );

    // Blink FSM
    //   state | meaning
    //   SHOW  | text visible
    //   HIDE  | text blanked
    blink_state_t     state, state_nxt;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= SHOW;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        if (BLINK_FRAMES == 0 || !bus.blink_on) begin
            state_nxt     = SHOW;
            frame_cnt_nxt = '0;
        end else if (bus.frame_start) begin
            if (frame_cnt == CNT_TC) begin
                frame_cnt_nxt = '0;
                state_nxt     = (state == SHOW) ? HIDE : SHOW;
            end else begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
    end

    // Next state drives blanking so a frame_start coinciding with a strobe
    // already affects the pixel leaving in that cycle.
    assign blank = (state_nxt == HIDE);
    assign lit   = pipe_out.hit & bus.rom_data[MSB_COL - pipe_out.col] & ~blank;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_on_q  <= 1'b0;
            pixel_vld_q <= 1'b0;
        end else begin
            pixel_vld_q <= bus.pix_en;
            if (bus.pix_en) begin
                pixel_on_q <= lit;
            end
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pixel_on  = pixel_on_q;
    assign bus.pixel_vld = pixel_vld_q;

endmodule

// File: tb/tb_font_glyph_reader.sv
// Bench for font_glyph_reader: ROM_LAT=1 and ROM_LAT=3 instances share stimulus and
// are checked against a queue-based pixel model and a pulse-counting blink model.
module tb_font_glyph_reader;

    localparam int X0 = 527;
    localparam int BF = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en_s = 1'b0;
    logic        frame_start_s = 1'b0;
    logic        blink_on_s = 1'b0;
    logic        glyph_hit_s = 1'b0;
    logic [9:0]  draw_x_s = '0;
    logic [10:0] addr_s = '0;
    logic        rom_mode = 1'b0;
    logic [7:0]  rom_force = '0;
    logic [7:0]  mem [2048];
    logic [7:0]  rs1 = '0;
    logic [7:0]  rs3 [3];

    int checks = 0;
    int errors = 0;

    font_glyph_reader_if bus1();
    font_glyph_reader_if bus3();

    assign bus1.pix_en      = pix_en_s;
    assign bus1.frame_start = frame_start_s;
    assign bus1.blink_on    = blink_on_s;
    assign bus1.DrawX       = draw_x_s;
    assign bus1.glyph_hit   = glyph_hit_s;
    assign bus1.addr_in     = addr_s;
    assign bus1.rom_data    = rom_mode ? rs1 : rom_force;
    assign bus3.pix_en      = pix_en_s;
    assign bus3.frame_start = frame_start_s;
    assign bus3.blink_on    = blink_on_s;
    assign bus3.DrawX       = draw_x_s;
    assign bus3.glyph_hit   = glyph_hit_s;
    assign bus3.addr_in     = addr_s;
    assign bus3.rom_data    = rom_mode ? rs3[2] : rom_force;

    font_glyph_reader #(.ROM_LAT(1), .X0(X0), .BLINK_FRAMES(BF)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus1));
    font_glyph_reader #(.ROM_LAT(3), .X0(X0), .BLINK_FRAMES(BF)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus3));

    always #5 Clk = ~Clk;

    // Font ROM models: advance only on the pixel strobe
    always @(posedge Clk) begin
        if (pix_en_s) begin
            rs1    <= mem[bus1.rom_addr];
            rs3[0] <= mem[bus3.rom_addr];
            rs3[1] <= rs3[0];
            rs3[2] <= rs3[1];
        end
    end

    // Reference model
    typedef struct {
        bit hit;
        int drawx;
        int addr;
    } pix_t;

    pix_t        q1[$];
    pix_t        q3[$];
    int          bcnt = 0;
    bit          hidden = 0;
    bit          exp_on1 = 0;
    bit          exp_on3 = 0;
    bit          exp_vld = 0;
    logic [10:0] exp_addr = '0;

    function automatic bit pix_lit(pix_t p, bit hid);
        int col;
        logic [7:0] d;
        col = (p.drawx - X0) & 7;
        d = rom_mode ? mem[p.addr] : rom_force;
        return p.hit && d[7-col] && !hid;
    endfunction

    function automatic void model_step();
        pix_t p;
        if (!blink_on_s) bcnt = 0;
        else if (frame_start_s) bcnt++;
        hidden = blink_on_s && (((bcnt / BF) % 2) == 1);
        exp_vld = pix_en_s;
        if (pix_en_s) begin
            p.hit = glyph_hit_s;
            p.drawx = int'(draw_x_s);
            p.addr = int'(addr_s);
            exp_addr = addr_s;
            q1.push_back(p);
            q3.push_back(p);
            exp_on1 = 0;
            if (q1.size() == 3) exp_on1 = pix_lit(q1.pop_front(), hidden);
            exp_on3 = 0;
            if (q3.size() == 5) exp_on3 = pix_lit(q3.pop_front(), hidden);
        end
    endfunction

    function automatic void model_reset();
        q1.delete();
        q3.delete();
        bcnt = 0;
        exp_on1 = 0;
        exp_on3 = 0;
        exp_vld = 0;
        exp_addr = '0;
    endfunction

    task automatic drive(input bit pe, input bit fs);
        pix_en_s = pe;
        frame_start_s = fs;
        @(posedge Clk);
        model_step();
        #1;
        pix_en_s = 1'b0;
        frame_start_s = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus1.pixel_on !== 1'b0 || bus3.pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_pixel_on: got %b/%b want 0/0", bus1.pixel_on, bus3.pixel_on);
        end
        checks++;
        if (bus1.pixel_vld !== 1'b0 || bus3.pixel_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_pixel_vld: got %b/%b want 0/0", bus1.pixel_vld, bus3.pixel_vld);
        end
        checks++;
        if (bus1.rom_addr !== 11'h000 || bus3.rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h/%h want 000", bus1.rom_addr, bus3.rom_addr);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_first_pixel();
        rom_mode = 0;
        rom_force = 8'h80;
        blink_on_s = 0;
        glyph_hit_s = 1;
        draw_x_s = 10'd527;
        addr_s = 11'h520;
        drive(1, 0);
        checks++;
        if (bus1.rom_addr !== 11'h520) begin
            errors++;
            $display("FAIL first_rom_addr: got %h want 520", bus1.rom_addr);
        end
        drive(0, 0);
        checks++;
        if (bus1.pixel_vld !== 1'b0) begin
            errors++;
            $display("FAIL gap_vld: got %b want 0", bus1.pixel_vld);
        end
        drive(1, 0);
        checks++;
        if (bus1.pixel_on !== exp_on1) begin
            errors++;
            $display("FAIL first_strobe1: got %b want %b", bus1.pixel_on, exp_on1);
        end
        drive(1, 0);
        checks++;
        if (bus1.pixel_on !== 1'b1 || bus1.pixel_vld !== 1'b1 || exp_on1 !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel: got on=%b vld=%b want 1/1", bus1.pixel_on, bus1.pixel_vld);
        end
    endtask

    task automatic test_column();
        draw_x_s = 10'd530;
        rom_force = 8'h10;
        for (int i = 0; i < 3; i++) drive(1, 0);
        checks++;
        if (bus1.pixel_on !== 1'b1 || bus1.pixel_on !== exp_on1) begin
            errors++;
            $display("FAIL col3_lit: got %b want 1", bus1.pixel_on);
        end
        rom_force = 8'hEF;
        drive(1, 0);
        checks++;
        if (bus1.pixel_on !== 1'b0 || bus1.pixel_on !== exp_on1) begin
            errors++;
            $display("FAIL col3_dark: got %b want 0", bus1.pixel_on);
        end
        checks++;
        if (bus3.pixel_on !== exp_on3) begin
            errors++;
            $display("FAIL col3_lat3: got %b want %b", bus3.pixel_on, exp_on3);
        end
    endtask

    task automatic test_no_hit();
        glyph_hit_s = 0;
        rom_force = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            draw_x_s = 10'($urandom_range(520, 600));
            addr_s = 11'($urandom);
            drive(1, 0);
            checks++;
            if (bus1.pixel_on !== exp_on1 || bus3.pixel_on !== exp_on3 ||
                (i >= 2 && bus1.pixel_on !== 1'b0)) begin
                errors++;
                $display("FAIL no_hit[%0d]: got %b/%b want %b/%b", i,
                         bus1.pixel_on, bus3.pixel_on, exp_on1, exp_on3);
            end
        end
    endtask

    task automatic test_blink();
        bit want;
        glyph_hit_s = 1;
        rom_force = 8'hFF;
        blink_on_s = 1;
        for (int i = 0; i < 5; i++) drive(1, 0);
        for (int f = 0; f < 6; f++) begin
            if (f > 0) drive(0, 1);
            want = ((f / 2) % 2) == 0;
            for (int s = 0; s < 4; s++) begin
                draw_x_s = 10'($urandom_range(527, 590));
                drive(1, 0);
                checks++;
                if (bus1.pixel_on !== want || bus3.pixel_on !== want ||
                    bus1.pixel_on !== exp_on1) begin
                    errors++;
                    $display("FAIL blink_f%0d_s%0d: got %b/%b want %b", f, s,
                             bus1.pixel_on, bus3.pixel_on, want);
                end
                drive(0, 0);
            end
        end
        drive(0, 1);
        drive(1, 0);
        checks++;
        if (bus1.pixel_on !== 1'b0 || bus1.pixel_on !== exp_on1) begin
            errors++;
            $display("FAIL blink_hide6: got %b want 0", bus1.pixel_on);
        end
        blink_on_s = 0;
        drive(1, 0);
        checks++;
        if (bus1.pixel_on !== 1'b1 || bus3.pixel_on !== 1'b1) begin
            errors++;
            $display("FAIL blink_drop: got %b/%b want 1/1", bus1.pixel_on, bus3.pixel_on);
        end
    endtask

    task automatic test_every_third();
        rom_mode = 1;
        blink_on_s = 0;
        for (int i = 0; i < 90; i++) begin
            if (i % 3 == 0) begin
                glyph_hit_s = ($urandom_range(0, 3) != 0);
                draw_x_s = 10'($urandom_range(500, 640));
                addr_s = 11'($urandom);
            end
            drive(i % 3 == 0, 0);
            checks++;
            if (bus3.pixel_on !== exp_on3 || bus3.pixel_vld !== exp_vld ||
                bus1.pixel_on !== exp_on1 || bus1.pixel_vld !== exp_vld) begin
                errors++;
                $display("FAIL third[%0d]: got on=%b/%b vld=%b/%b want on=%b/%b vld=%b", i,
                         bus1.pixel_on, bus3.pixel_on, bus1.pixel_vld, bus3.pixel_vld,
                         exp_on1, exp_on3, exp_vld);
            end
        end
    endtask

    task automatic test_random();
        rom_mode = 1;
        for (int i = 0; i < 400; i++) begin
            glyph_hit_s = ($urandom_range(0, 3) != 0);
            draw_x_s = 10'($urandom_range(500, 700));
            addr_s = 11'($urandom);
            blink_on_s = ($urandom_range(0, 15) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
            checks++;
            if (bus1.pixel_on !== exp_on1 || bus3.pixel_on !== exp_on3 ||
                bus1.pixel_vld !== exp_vld || bus3.pixel_vld !== exp_vld ||
                bus1.rom_addr !== exp_addr) begin
                errors++;
                $display("FAIL random[%0d]: got on=%b/%b vld=%b/%b addr=%h want on=%b/%b vld=%b addr=%h",
                         i, bus1.pixel_on, bus3.pixel_on, bus1.pixel_vld, bus3.pixel_vld,
                         bus1.rom_addr, exp_on1, exp_on3, exp_vld, exp_addr);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        rom_mode = 0;
        rom_force = 8'hFF;
        glyph_hit_s = 1;
        blink_on_s = 0;
        draw_x_s = 10'd531;
        for (int i = 0; i < 5; i++) drive(1, 0);
        checks++;
        if (bus1.pixel_on !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lit: got %b want 1", bus1.pixel_on);
        end
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus1.pixel_on !== 1'b0 || bus3.pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got %b/%b want 0/0", bus1.pixel_on, bus3.pixel_on);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            drive(1, 0);
            checks++;
            if (bus1.pixel_on !== exp_on1 || bus3.pixel_on !== exp_on3 ||
                (s <= 2 && bus1.pixel_on !== 1'b0) || (s <= 4 && bus3.pixel_on !== 1'b0) ||
                (s == 3 && bus1.pixel_on !== 1'b1)) begin
                errors++;
                $display("FAIL post_reset_s%0d: got %b/%b want %b/%b", s,
                         bus1.pixel_on, bus3.pixel_on, exp_on1, exp_on3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) rs3[i] = '0;
        test_reset();
        test_first_pixel();
        test_column();
        test_no_hit();
        test_blink();
        test_every_third();
        test_random();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/font_glyph_reader.md
# font_glyph_reader

Consumer side of the on-screen text address path: takes the per-pixel font-ROM row address and hit flag produced by the text sprite locators (e.g. the "ROUND" banner) and turns them into a registered pixel-on signal for the colour mapper. It drives the synchronous font ROM, pipelines the hit and column information to match ROM latency, and applies an optional frame-counted blink. It sits between the text sprite locators and the colour mapper in the VGA pixel path.

## Interface
- ROM_LAT, 1: font ROM read latency in pixel-enable steps; legal values 1..3.
- X0, 527: DrawX of the left edge of the first glyph; glyphs are 8 px wide and contiguous.
- BLINK_FRAMES, 30: frames per blink half-period; 0 disables blinking.
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_en  in  1  one-cycle strobe per pixel; the pipeline advances only on this strobe.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- blink_on  in  1  level; 1 enables blinking.
- DrawX  in  10  current pixel X.
- glyph_hit  in  1  OR of the locator's per-letter hit flags for this pixel.
- addr_in  in  11  font row address, char_code*16 + row.
- rom_addr  out  11  address to the font ROM.
- rom_data  in  8  ROM row data; bit 7 is the leftmost pixel.
- pixel_on  out  1  registered: text pixel is lit.
- pixel_vld  out  1  registered: pixel_on corresponds to a pixel ROM_LAT+1 strobes earlier.

## Operation
- On pix_en:
  - register rom_addr <= addr_in;
  - push {glyph_hit, col} into a shift pipeline of depth ROM_LAT, where col = (DrawX - X0) mod 8 (3-bit truncation of the 10-bit difference).
- On pix_en, pipeline output stage:
  - pixel_on <= hit_d & rom_data[7 - col_d] & ~blank;
  - pixel_vld <= 1.
- While pix_en = 0:
  - nothing advances;
  - pixel_vld <= 0;
  - pixel_on holds its value.
- Blink FSM, states SHOW and HIDE:
  - blank = 1 in HIDE only.
  - frame_cnt counts frame_start pulses. On reaching BLINK_FRAMES-1 it clears to 0 and the state toggles.
  - blink_on = 0 forces SHOW and clears frame_cnt, synchronously on the next Clk.
  - BLINK_FRAMES = 0 pins the FSM in SHOW.
  - frame_cnt width: $clog2(BLINK_FRAMES+1).
- glyph_hit = 0: pixel_on = 0 for that pixel regardless of rom_data. rom_addr is still updated, because the ROM read is harmless.

## Timing
- Reset values:
  - rom_addr = 0, pixel_on = 0, pixel_vld = 0;
  - pipeline hit bits = 0;
  - state = SHOW, frame_cnt = 0.
- Latency: pixel N (strobe k) produces pixel_on at the Clk edge of strobe k+ROM_LAT+1, together with pixel_vld.
- The ROM is sampled exactly ROM_LAT strobes after rom_addr is registered. The bench ROM model advances only on pix_en.
- frame_start coincident with pix_en: both take effect in the same cycle; the blink state change applies to the pixel being output in that cycle.
- Reset asserted mid-frame: all pipeline hits clear immediately. No lit pixel emerges until ROM_LAT+1 strobes after release.

## Structure
- Shared package (video_pkg) holds:
  - FONT_H = 16 and GLYPH_W = 8;
  - the font address width (11);
  - enum blink_state_t {SHOW, HIDE}.
- One sub-module, glyph_pipe: a parameterised ROM_LAT-deep shift register carrying {hit, col}, enabled by pix_en.

## Test plan
- Reset, then DrawX = 527, glyph_hit = 1, addr_in = 0x520, rom_data = 0x80, ROM_LAT = 1 -> pixel_on = 1 and pixel_vld = 1 on the 2nd strobe after. rom_addr = 0x520 after the 1st strobe.
- DrawX = 530 (col 3), rom_data = 0x10 -> pixel_on = 1. Same pixel with rom_data = 0xEF -> pixel_on = 0.
- glyph_hit = 0, rom_data = 0xFF for 20 strobes -> pixel_on stays 0 throughout.
- BLINK_FRAMES = 2, blink_on = 1, constant lit glyph -> pixel_on is 1 for frames 0-1, 0 for frames 2-3, 1 for frames 4-5. Dropping blink_on during HIDE -> pixel_on = 1 on the next strobe's output.
- pix_en toggling every 3rd Clk, ROM_LAT = 3 -> pixel_vld pulses only on strobe cycles. Output sequence equals the input sequence delayed by 4 strobes.
- Reset_n asserted with hit bits in flight -> pixel_on = 0 immediately and stays 0 for 2 strobes after release (ROM_LAT = 1).
